// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the rv32i pipeline.
//
// Owns the PC register and issues at most one instruction-memory request at a
// time. Fetched words are written into the IF/ID register. A fetched word that
// arrives while decode is stalled is parked in a one-entry hold buffer.
//
// Handshake: a request transfers on a rising edge where imem_req && imem_ready.
// The memory then returns exactly one imem_rvalid pulse, at least one cycle
// later, carrying imem_rdata. imem_req stays low until that response has been
// consumed, so there is never more than one request outstanding.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   new_pc        redirect target, sampled only when redirect=1
//   redirect      taken branch/jump: reload PC, flush IF/ID, kill in-flight data
//   stall         hazard stall: IF/ID holds, PC does not advance
//   imem_req      fetch request valid (low while rst=1)
//   imem_addr     fetch address (= pc)
//   imem_ready    memory accepts the request this cycle
//   imem_rvalid   read data valid
//   imem_rdata    instruction word
//   pc            current fetch PC
//   pc_plus_4     pc + 4, wraps modulo 2^32
//   ifid_valid    IF/ID holds a live instruction
//   ifid_pc       PC of the IF/ID instruction
//   ifid_instr    IF/ID instruction word
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] new_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_q, hold_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        ifid_we;
    logic [31:0] ifid_wdata;

    assign pc         = pc_q;
    assign pc_plus_4  = pc_q + 32'd4;
    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == S_FETCH) && !rst;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        hold_d       = hold_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_we      = 1'b0;
        ifid_wdata   = hold_q;

        // An unstalled IF/ID that receives nothing this cycle becomes a bubble.
        if (!stall) begin
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (!stall) begin
                        ifid_we    = 1'b1;
                        ifid_wdata = imem_rdata;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    ifid_we    = 1'b1;
                    ifid_wdata = hold_q;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (ifid_we) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = ifid_wdata;
            pc_d         = pc_plus_4;
        end

        // Redirect wins over stall and over any IF/ID write this cycle.
        if (redirect) begin
            pc_d         = new_pc;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = NOP_INSTR;
            case (state_q)
                S_FETCH: begin
                    // Request leaving this edge fetches the old path: drop its data.
                    if (imem_ready) begin
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // The stale response is arriving now: drop it here.
                        discard_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            hold_q       <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            hold_q       <= hold_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

endmodule
